// File: rtl/sfifo_pkg.sv
// Shared helpers for the synchronous FIFO: derived widths and parameter legality.
package sfifo_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

  // Storage address width: indexes 0..depth-1, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

  // Legal configuration: at least two words, thresholds inside the occupancy range.
  function automatic bit params_ok(input int depth, input int af, input int ae);
    return (depth >= 32'sd2) &&
           (af >= 32'sd1) && (af <= depth) &&
           (ae >= 32'sd0) && (ae <= depth - 32'sd1);
  endfunction

endpackage

// File: rtl/sfifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first on
// address collision). The storage array is never reset; only the read register is.
module sfifo_dpram
  import sfifo_pkg::*;
#(
  parameter int D_WIDTH = 48,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem_r [DEPTH];
  logic [D_WIDTH-1:0] rdata_r;

  // Storage write port.
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: loads on read enable, otherwise holds its last word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with occupancy count, almost-full/empty flags
// and sticky overflow/underflow errors. Any DEPTH >= 2 is supported; pointers
// wrap explicitly at DEPTH-1.
// Build option: define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through
// output; otherwise the popped word appears one cycle after the read.
module param_sync_fifo
  import sfifo_pkg::*;
#(
  parameter  int D_WIDTH   = 48,
  parameter  int DEPTH     = 256,
  parameter  int AF_THRESH = 254,
  parameter  int AE_THRESH = 2,
  localparam int CNT_W     = cnt_w(DEPTH),
  localparam int ADDR_W    = addr_w(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [D_WIDTH-1:0] i_data,
  input  logic               i_rd_en,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almst_full,
  output logic               o_almst_empty,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_ovf,
  output logic               o_udf,
  input  logic               i_clr_err
);

  if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $fatal(1, "param_sync_fifo: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 32'sd1);
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  CNT_AE    = CNT_W'(AE_THRESH);

  logic              wr_ok_s;
  logic              rd_ok_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W-1:0] wr_ptr_nxt_s;
  logic [ADDR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              almst_full_r;
  logic              almst_empty_r;
  logic              ovf_r;
  logic              udf_r;

  logic               ram_re_s;
  logic [ADDR_W-1:0]  ram_raddr_s;
  logic [D_WIDTH-1:0] ram_q_s;

  // Acceptance: a read needs data; a write needs room or a same-cycle read.
  always_comb begin
    rd_ok_s = i_rd_en & ~empty_r;
    wr_ok_s = i_wr_en & (~full_r | rd_ok_s);
  end

  // Next pointers with explicit wrap so non-power-of-two depths keep order.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_ok_s) begin
      wr_ptr_nxt_s = (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + ADDR_W'(1'b1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_ok_s) begin
      rd_ptr_nxt_s = (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + ADDR_W'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Next occupancy: a simultaneous accepted read and write leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count and flag registers; flags are precomputed from the next count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      full_r        <= 1'b0;
      empty_r       <= 1'b1;
      almst_full_r  <= 1'b0;
      almst_empty_r <= 1'b1;
    end else begin
      wr_ptr_r      <= wr_ptr_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      count_r       <= count_nxt_s;
      full_r        <= (count_nxt_s == CNT_DEPTH);
      empty_r       <= (count_nxt_s == '0);
      almst_full_r  <= (count_nxt_s >= CNT_AF);
      almst_empty_r <= (count_nxt_s <= CNT_AE);
    end
  end

  // Sticky error flags: setting wins over a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (i_wr_en & ~wr_ok_s) begin
        ovf_r <= 1'b1;
      end else if (i_clr_err) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (i_rd_en & empty_r) begin
        udf_r <= 1'b1;
      end else if (i_clr_err) begin
        udf_r <= 1'b0;
      end else begin
        udf_r <= udf_r;
      end
    end
  end

  sfifo_dpram #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .we      (wr_ok_s),
    .waddr   (wr_ptr_r),
    .wdata   (i_data),
    .re      (ram_re_s),
    .raddr   (ram_raddr_s),
    .rdata   (ram_q_s)
  );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // The RAM continuously prefetches the next head; a write landing on that
  // slot in the same cycle is forwarded because the RAM read is read-first.
  logic               byp_sel_r;
  logic [D_WIDTH-1:0] byp_data_r;

  assign ram_re_s    = 1'b1;
  assign ram_raddr_s = rd_ptr_nxt_s;

  // Forwarding register for writes that become the head word immediately.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      byp_sel_r  <= 1'b0;
      byp_data_r <= '0;
    end else begin
      byp_sel_r  <= wr_ok_s & (wr_ptr_r == rd_ptr_nxt_s);
      byp_data_r <= i_data;
    end
  end

  assign o_valid = ~empty_r;
  assign o_data  = byp_sel_r ? byp_data_r : ram_q_s;
`else
  // Standard mode: the RAM read register holds the last popped word.
  logic valid_r;

  assign ram_re_s    = rd_ok_s;
  assign ram_raddr_s = rd_ptr_r;

  // o_valid marks the cycle right after an accepted read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= rd_ok_s;
    end
  end

  assign o_valid = valid_r;
  assign o_data  = ram_q_s;
`endif

  assign o_full        = full_r;
  assign o_empty       = empty_r;
  assign o_almst_full  = almst_full_r;
  assign o_almst_empty = almst_empty_r;
  assign o_count       = count_r;
  assign o_ovf         = ovf_r;
  assign o_udf         = udf_r;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DEPTH=6, AF=5, AE=1, 8-bit data).
module tb_param_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 6;
  localparam int AF = 5;
  localparam int AE = 1;
  localparam int CW = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [DW-1:0] i_data = 8'h00;
  logic          i_rd_en = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_full, o_empty, o_almst_full, o_almst_empty;
  logic [CW-1:0] o_count;
  logic          o_ovf, o_udf;
  logic          i_clr_err = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  param_sync_fifo #(.D_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_data(i_data),
    .i_rd_en(i_rd_en), .o_data(o_data), .o_valid(o_valid), .o_full(o_full),
    .o_empty(o_empty), .o_almst_full(o_almst_full), .o_almst_empty(o_almst_empty),
    .o_count(o_count), .o_ovf(o_ovf), .o_udf(o_udf), .i_clr_err(i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    i_wr_en = 1'b1; i_data = d;
    tick();
    i_wr_en = 1'b0;
  endtask

  // Pop one word; returns the valid flag and data that belong to that pop.
  task automatic pop(output logic v, output logic [DW-1:0] d);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    v = o_valid; d = o_data;
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
`else
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    v = o_valid; d = o_data;
`endif
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", o_empty); end
    n_cmp++; if (o_almst_empty !== 1'b1) begin n_err++; $display("FAIL rst_ae: got %b want 1", o_almst_empty); end
    n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", o_full); end
    n_cmp++; if (o_almst_full !== 1'b0) begin n_err++; $display("FAIL rst_af: got %b want 0", o_almst_full); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", o_data); end
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", o_count); end
    n_cmp++; if ({o_ovf, o_udf} !== 2'b00) begin n_err++; $display("FAIL rst_sticky: got %b want 00", {o_ovf, o_udf}); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= DEPTH; i++) begin
      push(DW'(i));
      n_cmp++; if (int'(o_count) !== i) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, o_count, i); end
      n_cmp++; if (o_almst_empty !== (i <= AE)) begin n_err++; $display("FAIL fill_ae[%0d]: got %b want %b", i, o_almst_empty, (i <= AE)); end
      n_cmp++; if (o_almst_full !== (i >= AF)) begin n_err++; $display("FAIL fill_af[%0d]: got %b want %b", i, o_almst_full, (i >= AF)); end
      n_cmp++; if (o_full !== (i == DEPTH)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, o_full, (i == DEPTH)); end
    end
    n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL fill_ovf: got %b want 0", o_ovf); end
  endtask

  task automatic test_overflow;
    logic v;
    logic [DW-1:0] d;
    push(8'hAA);
    n_cmp++; if (o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", o_ovf); end
    n_cmp++; if (o_count !== 3'd6) begin n_err++; $display("FAIL ovf_count: got %0d want 6", o_count); end
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", o_ovf); end
    for (int i = 1; i <= DEPTH; i++) begin
      pop(v, d);
      n_cmp++; if ({v, d} !== {1'b1, DW'(i)}) begin n_err++; $display("FAIL ovf_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, v, d, DW'(i)); end
    end
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty: got %b want 1", o_empty); end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp;
    logic v;
    logic [DW-1:0] d;
    for (int k = 0; k < 20; k++) begin
      push(DW'(k + 8'h10));
      q.push_back(DW'(k + 8'h10));
      if (k >= 2) begin
        pop(v, d);
        exp = q.pop_front();
        n_cmp++; if ({v, d} !== {1'b1, exp}) begin n_err++; $display("FAIL wrap[%0d]: got v=%b d=%h want d=%h", k, v, d, exp); end
      end
    end
    while (q.size() > 0) begin
      pop(v, d);
      exp = q.pop_front();
      n_cmp++; if ({v, d} !== {1'b1, exp}) begin n_err++; $display("FAIL wrap_tail: got v=%b d=%h want d=%h", v, d, exp); end
    end
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL wrap_count: got %0d want 0", o_count); end
  endtask

  task automatic test_simultaneous;
    logic v;
    logic [DW-1:0] d;
    for (int i = 1; i <= DEPTH; i++) push(DW'(8'h20 + i));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    n_cmp++; if (o_data !== 8'h21) begin n_err++; $display("FAIL sim_head: got %h want 21", o_data); end
`endif
    i_wr_en = 1'b1; i_data = 8'h55; i_rd_en = 1'b1;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    n_cmp++; if (o_count !== 3'd6) begin n_err++; $display("FAIL sim_full_count: got %0d want 6", o_count); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL sim_full_ovf: got %b want 0", o_ovf); end
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    n_cmp++; if ({o_valid, o_data} !== {1'b1, 8'h21}) begin n_err++; $display("FAIL sim_full_rd: got v=%b d=%h want v=1 d=21", o_valid, o_data); end
`endif
    for (int i = 2; i <= DEPTH + 1; i++) begin
      pop(v, d);
      n_cmp++; if (d !== ((i <= DEPTH) ? DW'(8'h20 + i) : 8'h55)) begin n_err++; $display("FAIL sim_drain[%0d]: got %h", i, d); end
    end
    i_wr_en = 1'b1; i_data = 8'h77; i_rd_en = 1'b1;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    n_cmp++; if (o_count !== 3'd1) begin n_err++; $display("FAIL sim_empty_count: got %0d want 1", o_count); end
    n_cmp++; if (o_udf !== 1'b1) begin n_err++; $display("FAIL sim_empty_udf: got %b want 1", o_udf); end
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    n_cmp++; if (o_udf !== 1'b0) begin n_err++; $display("FAIL udf_clr: got %b want 0", o_udf); end
    pop(v, d);
    n_cmp++; if ({v, d} !== {1'b1, 8'h77}) begin n_err++; $display("FAIL sim_empty_data: got v=%b d=%h want v=1 d=77", v, d); end
  endtask

  task automatic test_latency;
    push(8'h3C);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    n_cmp++; if ({o_valid, o_data} !== {1'b1, 8'h3C}) begin n_err++; $display("FAIL lat_fwft: got v=%b d=%h want v=1 d=3c", o_valid, o_data); end
    i_rd_en = 1'b1; tick(); i_rd_en = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL lat_fwft_after: got %b want 0", o_valid); end
`else
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL lat_idle: got %b want 0", o_valid); end
    i_rd_en = 1'b1; tick(); i_rd_en = 1'b0;
    n_cmp++; if ({o_valid, o_data} !== {1'b1, 8'h3C}) begin n_err++; $display("FAIL lat_std: got v=%b d=%h want v=1 d=3c", o_valid, o_data); end
    tick();
    n_cmp++; if ({o_valid, o_data} !== {1'b0, 8'h3C}) begin n_err++; $display("FAIL lat_hold: got v=%b d=%h want v=0 d=3c", o_valid, o_data); end
`endif
  endtask

  task automatic test_reset_midrun;
    logic v;
    logic [DW-1:0] d;
    i_rd_en = 1'b1; tick(); i_rd_en = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(8'hC0 + i));
    n_cmp++; if ({o_count, o_udf} !== {3'd4, 1'b1}) begin n_err++; $display("FAIL mid_pre: got count=%0d udf=%b want 4/1", o_count, o_udf); end
    i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
    n_cmp++; if ({o_empty, o_count, o_valid} !== {1'b1, 3'd0, 1'b0}) begin n_err++; $display("FAIL mid_rst: got e=%b c=%0d v=%b want 1/0/0", o_empty, o_count, o_valid); end
    n_cmp++; if ({o_ovf, o_udf} !== 2'b00) begin n_err++; $display("FAIL mid_sticky: got %b want 00", {o_ovf, o_udf}); end
    push(8'h99);
    pop(v, d);
    n_cmp++; if ({v, d} !== {1'b1, 8'h99}) begin n_err++; $display("FAIL mid_new: got v=%b d=%h want v=1 d=99", v, d); end
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", o_empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_latency();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter D_WIDTH, default 48, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 256, storage words; any integer >=2, not restricted to powers of two.
REQ-003 SHALL have parameter AF_THRESH, default 254, occupancy at or above which almost-full asserts (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, occupancy at or below which almost-empty asserts (0..DEPTH-1).
REQ-005 SHALL have ports: i_clk  in  1  clock; i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: i_wr_en  in  1  write request; i_data  in  D_WIDTH  write data.
REQ-007 SHALL have ports: i_rd_en  in  1  read request (pop); o_data  out  D_WIDTH  read data; o_valid  out  1  o_data qualifier.
REQ-008 SHALL have ports: o_full, o_empty, o_almst_full, o_almst_empty  out  1 each  status flags; o_count  out  CNT_W  occupancy.
REQ-009 SHALL have ports: o_ovf, o_udf  out  1 each  sticky overflow/underflow; i_clr_err  in  1  clears sticky flags.

Function
REQ-010 SHALL accept a write when i_wr_en=1 and (o_full=0, or o_full=1 with a read accepted the same cycle).
REQ-011 SHALL accept a read when i_rd_en=1 and o_empty=0; a simultaneous write into an empty FIFO is accepted, the read is not.
REQ-012 SHALL advance write/read pointers by one per accepted access, wrapping from DEPTH-1 to 0 explicitly.
REQ-013 SHALL update o_count: +1 write only, -1 read only, unchanged when both or neither accepted; never exceeds DEPTH or underflows.
REQ-014 SHALL drive o_full = (o_count==DEPTH), o_empty = (o_count==0), o_almst_full = (o_count>=AF_THRESH), o_almst_empty = (o_count<=AE_THRESH), all from registered state.
REQ-015 SHALL set o_ovf on the edge after i_wr_en=1 with write rejected, and o_udf on the edge after i_rd_en=1 with o_empty=1; both hold until i_clr_err=1 or reset (set wins over clear in the same cycle).
REQ-016 SHALL not modify storage or pointers on rejected accesses.
REQ-017 SHALL preserve FIFO order across pointer wrap for any DEPTH.

Reset
REQ-018 SHALL on i_rst_n=0 at a clock edge clear pointers and o_count, giving o_empty=1, o_almst_empty=1, o_full=0, o_almst_full=0, o_valid=0, o_data=0, o_ovf=0, o_udf=0.
REQ-019 SHALL discard all contents on reset mid-operation; storage array itself is not reset; reset takes priority over all requests.

Configuration
REQ-020 SHALL, with macro PARAM_SYNC_FIFO_FWFT_EN undefined (standard mode), present the popped word on o_data with o_valid=1 one cycle after the accepted read; o_valid=0 and o_data holds last value otherwise.
REQ-021 SHALL, with PARAM_SYNC_FIFO_FWFT_EN defined (first-word-fall-through), drive o_valid = ~o_empty and o_data = head word whenever o_valid=1; i_rd_en pops the shown word; a write into an empty FIFO appears on o_data at the edge after its acceptance.
REQ-022 SHALL keep flag, count, and sticky-error behaviour identical in both modes.

Structure
REQ-023 SHALL place CNT_W/ADDR_W derivation functions ($clog2(DEPTH+1), $clog2(DEPTH)) and parameter legality checks in shared package sfifo_pkg.
REQ-024 SHALL instantiate one sub-module sfifo_dpram: simple dual-port RAM, one write port, one synchronous read port, D_WIDTH x DEPTH.
REQ-025 SHALL fail elaboration when DEPTH<2, AF_THRESH outside 1..DEPTH, or AE_THRESH outside 0..DEPTH-1.

Verification
REQ-026 Fill: DEPTH=6, AF=5, AE=1, write 0x1..0x6 -> o_count 1..6, o_almst_empty drops at count 2, o_almst_full at 5, o_full at 6, o_ovf=0.
REQ-027 Overflow: full DEPTH=6, i_wr_en=1 with 0xAA, no read -> o_ovf=1 next cycle, o_count stays 6, 0xAA never read; i_clr_err -> o_ovf=0.
REQ-028 Wrap: DEPTH=6, 20 interleaved writes/reads of incrementing data -> read sequence equals write sequence, pointers cross 5->0 three times.
REQ-029 Simultaneous: full, write 0x55 + read same cycle -> o_count stays 6, 0x55 read last; empty, write+read -> o_count 1, o_udf=1.
REQ-030 Latency: standard mode, read at cycle N -> o_valid=1 with head data at N+1; FWFT mode, write to empty at N -> o_valid=1, o_data=word at N+1.
REQ-031 Reset mid-run: count 4, assert i_rst_n=0 one cycle -> o_empty=1, o_count=0, o_valid=0, sticky flags 0; subsequent write/read returns new data only.
